corner_sequence_ctrl: RTL
=========================

Name: corner_sequence_ctrl

Overview:
- Gesture/sequence controller driven by the per-frame corner pass flags of the 4-way colour region detector (LT/RT/LB/RB).
- Samples the flags once per frame at vsync rise and debounces them over several frames.
- Steps through a programmable 4-corner sequence with a per-step frame timeout.
- Reports progress, success (done) or failure to the top-level display/LED logic.

Parameters:
- HOLD_FRAMES, 3: consecutive frames a single corner must be active to count as a hit (min 1).
- TIMEOUT_FRAMES, 300: frames allowed per step without advancing before FAIL (min 2).

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  synchronous active-low reset
- vsync  in  1  frame sync; the same signal that feeds the detector
- pass_lt  in  1  detector flag, left-top
- pass_rt  in  1  detector flag, right-top
- pass_lb  in  1  detector flag, left-bottom
- pass_rb  in  1  detector flag, right-bottom
- seq_cfg  in  8  sequence, 4 corner codes; [1:0] is the first step. Codes: 0=LT, 1=RT, 2=LB, 3=RB.
- start  in  1  one-cycle pulse that begins or restarts a sequence
- abort  in  1  one-cycle pulse that returns the block to IDLE
- busy  out  1  high in WAIT_HIT or WAIT_REL
- step_idx  out  2  index of the current expected step
- expect_corner  out  2  corner code of the current expected step
- corner_mask  out  4  last sampled flags {rb,lb,rt,lt}
- step_pulse  out  1  one-cycle pulse on each accepted step
- done  out  1  level, sequence completed
- fail  out  1  level, wrong corner or timeout
- state  out  3  FSM state for debug: IDLE=0, WAIT_HIT=1, WAIT_REL=2, DONE=3, FAIL=4

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs are 0. Internal counters and the latched sequence are cleared. The vsync delay register is set to 0.
- Reset mid-operation: immediate return to the reset values on that edge.
- Frame tick: ftick = vsync & ~vsync_d, where vsync_d is vsync registered once. On the ftick cycle the detector flags still hold the previous frame's result. The flags are sampled only on that cycle.
- corner_mask updates on every ftick in every state.
- Classification of each sample:
  - NONE: no flag set.
  - MULTI: two or more flags set.
  - SINGLE(c): exactly one flag set, corner c.
- IDLE:
  - start latches seq_cfg and sets step_idx=0, hold_cnt=0, wrong_cnt=0, to_cnt=0; next state WAIT_HIT.
  - ftick is ignored.
- WAIT_HIT, on each ftick:
  - to_cnt increments.
  - SINGLE(c == expect_corner): hold_cnt+1 and wrong_cnt=0. When hold_cnt reaches HOLD_FRAMES, the step is accepted:
    - step_pulse=1 for one cycle; hold_cnt=0, to_cnt=0.
    - If step_idx==3: next state DONE, with done=1.
    - Otherwise: step_idx+1, next state WAIT_REL.
  - SINGLE(c != expect_corner): wrong_cnt+1 and hold_cnt=0. When wrong_cnt reaches HOLD_FRAMES: next state FAIL.
  - NONE or MULTI: hold_cnt=0, wrong_cnt=0.
  - If to_cnt reaches TIMEOUT_FRAMES and no step is accepted on the same tick: next state FAIL.
  - Priority on the same tick: accept > wrong-corner fail > timeout.
- WAIT_REL, on each ftick:
  - to_cnt increments.
  - NONE moves to WAIT_HIT with counters cleared.
  - The timeout rule is the same as in WAIT_HIT.
  - This state stops the same corner counting twice when two consecutive steps use the same code.
- DONE / FAIL:
  - done or fail is held high.
  - start restarts as in IDLE and clears done/fail on the same edge.
- Outputs:
  - All outputs are registered and change on the clk edge that consumes ftick. Latency from ftick to output is 1 cycle.
  - expect_corner = latched sequence entry selected by step_idx.
  - seq_cfg changes while busy have no effect.
- Simultaneous events:
  - abort + start on the same cycle: abort wins, and the block goes to IDLE.
  - abort from any state goes to IDLE and clears done/fail/step_idx.
  - start while busy is ignored.
  - start on an ftick cycle in IDLE/DONE/FAIL: the start is taken and that ftick is not evaluated.
- Counter widths are sized so that TIMEOUT_FRAMES and HOLD_FRAMES are reachable without wrap. Counters saturate; they never wrap.

Test Plan:
- Bench settings: HOLD_FRAMES=3, TIMEOUT_FRAMES=10, seq_cfg=8'b11_10_01_00 (LT,RT,LB,RB).
- Happy path:
  - Stimulus: start; for each step, hold the correct flag for 3 frames, then NONE for 1 frame.
  - Required: step_pulse fires 4 times, step_idx goes 0→1→2→3, done=1 one cycle after the 12th hit ftick, fail=0, busy=0.
- Wrong corner:
  - Stimulus: after start, pass_rb alone for 3 frames.
  - Required: fail=1, state=4, step_idx=0. A 2-frame glitch followed by NONE does not fail.
- Timeout:
  - Stimulus: after start, NONE for 10 frames.
  - Required: fail=1 on the 10th ftick. Correct hit on frame 10 instead: accepted, no fail.
- MULTI and release:
  - Stimulus: LT+RT together for 5 frames, then LT alone for 3 frames.
  - Required: no progress during MULTI, then step 0 accepted.
  - Stimulus: with seq_cfg=8'b00_00_00_00, hold LT continuously.
  - Required: only step 0 is accepted until one NONE frame.
- Control and reset:
  - Stimulus: start+abort on the same cycle.
  - Required: state=0.
  - Stimulus: start while busy.
  - Required: ignored.
  - Stimulus: rst_n=0 mid-sequence at step_idx=2.
  - Required: all outputs 0 on the next edge.

Source files
------------

// File: rtl/corner_sequence_ctrl.sv
// corner_sequence_ctrl: debounced 4-corner gesture sequencer driven by per-frame detector flags
module corner_sequence_ctrl #(
    parameter int HOLD_FRAMES    = 3,
    parameter int TIMEOUT_FRAMES = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       pass_lt,
    input  logic       pass_rt,
    input  logic       pass_lb,
    input  logic       pass_rb,
    input  logic [7:0] seq_cfg,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic [1:0] step_idx,
    output logic [1:0] expect_corner,
    output logic [3:0] corner_mask,
    output logic       step_pulse,
    output logic       done,
    output logic       fail,
    output logic [2:0] state
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HIT  = 3'd1,
        S_REL  = 3'd2,
        S_DONE = 3'd3,
        S_FAIL = 3'd4
    } state_t;
    state_t r_state, w_state;
    logic          r_vsync_d;
    logic [7:0]    r_seq, w_seq;
    logic [1:0]    r_step, w_step;
    logic [HW-1:0] r_hold, w_hold, r_wrong, w_wrong, w_hold_inc, w_wrong_inc;
    logic [TW-1:0] r_to, w_to, w_to_inc;
    logic [3:0]    r_mask, w_flags;
    logic          r_pulse, w_pulse;
    logic          w_ftick, w_none, w_single, w_match, w_accept, w_wrong_fail, w_timeout, w_busy;
    logic [1:0]    w_code;
    assign w_flags      = {pass_rb, pass_lb, pass_rt, pass_lt};
    assign w_ftick      = vsync & ~r_vsync_d;
    assign w_none       = w_flags == 4'd0;
    assign w_single     = !w_none && ((w_flags & (w_flags - 4'd1)) == 4'd0);
    assign w_code       = w_flags[1] ? 2'd1 : w_flags[2] ? 2'd2 : w_flags[3] ? 2'd3 : 2'd0;
    assign w_match      = w_single && (w_code == expect_corner);
    // counters saturate at their terminal value instead of wrapping
    assign w_hold_inc   = (r_hold == HW'(HOLD_FRAMES)) ? r_hold : r_hold + HW'(1);
    assign w_wrong_inc  = (r_wrong == HW'(HOLD_FRAMES)) ? r_wrong : r_wrong + HW'(1);
    assign w_to_inc     = (r_to == TW'(TIMEOUT_FRAMES)) ? r_to : r_to + TW'(1);
    assign w_accept     = w_match && (w_hold_inc >= HW'(HOLD_FRAMES));
    assign w_wrong_fail = w_single && !w_match && (w_wrong_inc >= HW'(HOLD_FRAMES));
    assign w_timeout    = w_to_inc >= TW'(TIMEOUT_FRAMES);
    assign w_busy       = (r_state == S_HIT) || (r_state == S_REL);
    always_comb begin
        w_state = r_state;
        w_seq   = r_seq;
        w_step  = r_step;
        w_hold  = r_hold;
        w_wrong = r_wrong;
        w_to    = r_to;
        w_pulse = 1'b0;
        if (abort) begin
            w_state = S_IDLE;
            w_step  = '0;
            w_hold  = '0;
            w_wrong = '0;
            w_to    = '0;
        end else if (start && !w_busy) begin
            w_state = S_HIT;
            w_seq   = seq_cfg;
            w_step  = '0;
            w_hold  = '0;
            w_wrong = '0;
            w_to    = '0;
        end else if (w_ftick && r_state == S_HIT) begin
            w_pulse = w_accept;
            w_step  = (w_accept && r_step != 2'd3) ? r_step + 2'd1 : r_step;
            w_hold  = (w_match && !w_accept) ? w_hold_inc : '0;
            w_wrong = (w_single && !w_match) ? w_wrong_inc : '0;
            w_to    = w_accept ? '0 : w_to_inc;
            w_state = w_accept ? ((r_step == 2'd3) ? S_DONE : S_REL) :
                      (w_wrong_fail || w_timeout) ? S_FAIL : S_HIT;
        end else if (w_ftick && r_state == S_REL) begin
            w_to    = w_none ? '0 : w_to_inc;
            w_state = w_none ? S_HIT : w_timeout ? S_FAIL : S_REL;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_vsync_d <= 1'b0;
            r_seq     <= '0;
            r_step    <= '0;
            r_hold    <= '0;
            r_wrong   <= '0;
            r_to      <= '0;
            r_mask    <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_vsync_d <= vsync;
            r_seq     <= w_seq;
            r_step    <= w_step;
            r_hold    <= w_hold;
            r_wrong   <= w_wrong;
            r_to      <= w_to;
            r_mask    <= w_ftick ? w_flags : r_mask;
            r_pulse   <= w_pulse;
        end
    end
    assign expect_corner = r_seq[{r_step, 1'b0} +: 2];
    assign busy          = w_busy;
    assign step_idx      = r_step;
    assign corner_mask   = r_mask;
    assign step_pulse    = r_pulse;
    assign done          = r_state == S_DONE;
    assign fail          = r_state == S_FAIL;
    assign state         = r_state;
endmodule
